// File: rtl/seq_serializer.sv
// Parallel-in/serial-out stage feeding the sequence detector: one-entry holding
// register behind a valid/ready handshake, then a shifter that streams words gap-free.
module seq_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] shreg_q, shreg_n;
  logic [WIDTH-1:0] hold_q, hold_n;
  logic             hold_full_q, hold_full_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [WIDTH-1:0] shifted;
  logic             accept;
  logic             head_n;

  // Holding register is the only acceptance point; it is never open during reset.
  assign din_ready = reset && !hold_full_q;
  assign accept    = din_valid && din_ready;

  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
  assign head_n  = MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0];

  // Next-state: hold->shift transfer, bit shifting, and word capture.
  always_comb begin
    state_n     = state_q;
    shreg_n     = shreg_q;
    hold_n      = hold_q;
    hold_full_n = hold_full_q;
    cnt_n       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shreg_n     = hold_q;
          hold_full_n = 1'b0;
          cnt_n       = '0;
          state_n     = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          // Reload on the last-bit edge so consecutive words abut.
          if (hold_full_q) begin
            shreg_n     = hold_q;
            hold_full_n = 1'b0;
          end else begin
            shreg_n = shifted;
            state_n = IDLE;
          end
          cnt_n = '0;
        end else begin
          shreg_n = shifted;
          cnt_n   = CNT_W'(cnt_q + 1'b1);
        end
      end
    endcase

    // Accept and unload are mutually exclusive: accept needs hold empty, unload needs it full.
    if (accept) begin
      hold_n      = din;
      hold_full_n = 1'b1;
    end
  end

  // State and outputs registered together; outputs mirror the next registered state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      word_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      shreg_q     <= shreg_n;
      hold_q      <= hold_n;
      hold_full_q <= hold_full_n;
      cnt_q       <= cnt_n;
      ser_valid   <= (state_n == SHIFT);
      ser_out     <= (state_n == SHIFT) && head_n;
      word_done   <= (state_n == SHIFT) && (cnt_n == LAST);
      busy        <= (state_n == SHIFT) || hold_full_n;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: MSB-first and LSB-first instances, streaming,
// back-pressure and mid-word reset, with hand-computed serial sequences.
module tb_seq_serializer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] din, d1;
  logic       din_valid, v1;
  logic       din_ready, ser_out, ser_valid, word_done, busy;
  logic       din_ready1, ser_out1, ser_valid1, word_done1, busy1;

  int errors = 0;
  int checks = 0;

  logic [7:0] words [0:2];
  logic [7:0] w;

  always #5 clock = ~clock;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .word_done(word_done), .busy(busy)
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset(reset), .din(d1), .din_valid(v1),
    .din_ready(din_ready1), .ser_out(ser_out1), .ser_valid(ser_valid1),
    .word_done(word_done1), .busy(busy1)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Feed n words from words[] with din_valid held high; collect and check the serial stream.
  task automatic stream(input int n);
    int idx, nbits, gaps, stall, wdc, extra;
    logic acc;
    logic [7:0] ew;
    idx = 0; nbits = 0; gaps = 0; stall = 0; wdc = 0; extra = 0;
    din = words[0];
    din_valid = 1'b1;
    for (int cyc = 0; cyc < n * 8 + 6; cyc++) begin
      acc = din_valid && din_ready;
      if (din_valid && !din_ready) stall++;
      if (ser_valid) begin
        if (nbits < n * 8) begin
          ew = words[2'(nbits / 8)];
          chk1("stream_bit", ser_out, ew[3'(7 - (nbits % 8))]);
          chk1("stream_word_done", word_done, (nbits % 8) == 7);
          if (word_done) wdc++;
          nbits++;
        end else begin
          extra++;
        end
      end else if (nbits > 0 && nbits < n * 8) begin
        gaps++;
      end
      step();
      if (acc) begin
        idx++;
        if (idx < n) din = words[2'(idx)];
        else din_valid = 1'b0;
      end
    end
    chkn("stream_nbits", nbits, n * 8);
    chkn("stream_gaps", gaps, 0);
    chkn("stream_extra_bits", extra, 0);
    chkn("stream_word_done_count", wdc, n);
    chkn("stream_words_accepted", idx, n);
    if (n > 1) chk1("stream_backpressure_seen", stall > 0, 1'b1);
    chk1("stream_idle_valid", ser_valid, 1'b0);
    chk1("stream_idle_busy", busy, 1'b0);
  endtask

  initial begin
    int seen;
    reset = 1'b0; din = '0; din_valid = 1'b0; d1 = '0; v1 = 1'b0;

    // Reset state
    #2;
    chk1("rst_ser_valid", ser_valid, 1'b0);
    chk1("rst_ser_out", ser_out, 1'b0);
    chk1("rst_word_done", word_done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_din_ready", din_ready, 1'b0);
    step();
    reset = 1'b1;
    #1;
    chk1("post_rst_din_ready", din_ready, 1'b1);

    // Single word 0xA5, MSB first
    w = 8'hA5;
    din = w; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    chk1("a5_busy_held", busy, 1'b1);
    chk1("a5_not_yet_valid", ser_valid, 1'b0);
    chk1("a5_ready_low_full", din_ready, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk1("a5_valid", ser_valid, 1'b1);
      chk1("a5_bit", ser_out, w[3'(7 - i)]);
      chk1("a5_word_done", word_done, i == 7);
      step();
    end
    chk1("a5_end_valid", ser_valid, 1'b0);
    chk1("a5_end_out", ser_out, 1'b0);
    chk1("a5_end_busy", busy, 1'b0);
    chk1("a5_end_ready", din_ready, 1'b1);

    // Back-to-back 0xA5, 0x3C
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h00;
    stream(2);

    // Three words with din_valid held
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    stream(3);

    // Detector-facing pattern 10101011
    words[0] = 8'b1010_1011;
    stream(1);

    // LSB-first instance, word 0x01
    d1 = 8'h01; v1 = 1'b1;
    step();
    v1 = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      chk1("lsb_valid", ser_valid1, 1'b1);
      chk1("lsb_bit", ser_out1, i == 0);
      chk1("lsb_word_done", word_done1, i == 7);
      step();
    end
    chk1("lsb_end_valid", ser_valid1, 1'b0);

    // Reset during 4th bit of 0xFF with 0x0F held
    din = 8'hFF; din_valid = 1'b1;
    step();                      // accept 0xFF
    din = 8'h0F;
    step();                      // load; bit 1 on line, hold empty
    step();                      // accept 0x0F; bit 2
    din_valid = 1'b0;
    chk1("mid_hold_full", din_ready, 1'b0);
    step();                      // bit 3
    step();                      // bit 4
    chk1("mid_bit4_valid", ser_valid, 1'b1);
    chk1("mid_bit4_out", ser_out, 1'b1);
    reset = 1'b0;
    #1;
    chk1("mid_rst_valid", ser_valid, 1'b0);
    chk1("mid_rst_out", ser_out, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_ready", din_ready, 1'b0);
    step();
    reset = 1'b1;
    #1;
    chk1("mid_release_ready", din_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (ser_valid || busy) seen++;
      step();
    end
    chkn("mid_held_word_dropped", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
